// File: rtl/fm_modulator_if.sv
// Audio sample stream from the codec/I2S front end into the FM modulator.
// The master drives a sample word plus a one-cycle strobe; the slave captures it.
interface fm_modulator_if #(
    parameter int AUDIO_W = 16
) ();
    logic [AUDIO_W-1:0] sample;
    logic               sample_valid;

    modport master (output sample, output sample_valid);
    modport slave  (input  sample, input  sample_valid);
endinterface

// File: rtl/fm_modulator.sv
// FM modulator: audio capture with a sample-loss watchdog, a deviation multiply,
// carrier offset and a phase-accumulator NCO exporting phase MSBs and a square wave.
module fm_modulator #(
    parameter int                 PHASE_W        = 32,
    parameter int                 AUDIO_W        = 16,
    parameter int                 GAIN_W         = 9,
    parameter int unsigned        DEV_GAIN       = 197,
    parameter logic [PHASE_W-1:0] CARRIER_INC    = PHASE_W'(919123001),
    parameter int                 TIMEOUT_CYCLES = 2048,
    parameter int                 PHASE_OUT_W    = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    fm_modulator_if.slave          audio,
    output logic [PHASE_OUT_W-1:0] phase_out,
    output logic                   rf_out,
    output logic [PHASE_W-1:0]     freq_word,
    output logic                   stale
);
    localparam int                     PROD_W  = AUDIO_W + GAIN_W;
    localparam int                     CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    // Gain is unsigned; a zero MSB lets it join a signed multiply unchanged.
    localparam logic signed [GAIN_W:0] GAIN_S  = {1'b0, GAIN_W'(DEV_GAIN)};

    logic signed [AUDIO_W-1:0] r_s;
    logic signed [PROD_W-1:0]  r_prod;
    logic [PHASE_W-1:0]        r_freq;
    logic [PHASE_W-1:0]        r_phase;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_stale;

    logic signed [PROD_W-1:0]  w_prod;
    logic [PHASE_W-1:0]        w_prod_ext;
    logic                      w_expire;

    // Operands are widened to PROD_W first, so the low PROD_W bits are the exact product.
    assign w_prod     = PROD_W'(r_s) * PROD_W'(GAIN_S);
    assign w_prod_ext = {{(PHASE_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};
    assign w_expire   = (r_cnt == CNT_MAX - CNT_W'(1));

    // A strobe always beats watchdog expiry on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s     <= '0;
            r_cnt   <= CNT_MAX;
            r_stale <= 1'b1;
        end else if (audio.sample_valid) begin
            r_s     <= audio.sample;
            r_cnt   <= '0;
            r_stale <= 1'b0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_expire) begin
                r_s     <= '0;
                r_stale <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod <= '0;
            r_freq <= CARRIER_INC;
        end else begin
            r_prod <= w_prod;
            r_freq <= CARRIER_INC + w_prod_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_phase <= '0;
        else if (en)
            r_phase <= r_phase + r_freq;
    end

    assign phase_out = r_phase[PHASE_W-1 -: PHASE_OUT_W];
    assign rf_out    = en & r_phase[PHASE_W-1];
    assign freq_word = r_freq;
    assign stale     = r_stale;
endmodule
